// File: rtl/fir_memory_arbiter_if.sv
// Requester-side bus of the FIR coefficient/sample RAM arbiter.
// The requester uses the master modport, the arbiter the slave modport.
interface fir_memory_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 64
);
    logic                  req;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic                  waitrequest;
    logic                  readdatavalid;
    logic [DATA_W-1:0]     readdata;

    modport master (
        output req, write, address, byteenable, writedata,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  req, write, address, byteenable, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/fir_memory_arbiter.sv
// Round-robin arbiter sharing one RAM port between the FIR tap sequencer (m0)
// and the host loader (m1); read data is steered back by a latency-matched tag pipe.
module fir_memory_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_memory_arbiter_if.slave   m0,
    fir_memory_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic [CNT_W-1:0]      gnt_cnt0,
    output logic [CNT_W-1:0]      gnt_cnt1
);
    localparam int              BE_W    = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic                   prio_r;
    logic                   gnt0_s;
    logic                   gnt1_s;
    logic                   accept_s;
    logic                   sel_write_s;
    logic [ADDR_W-1:0]      sel_address_s;
    logic [BE_W-1:0]        sel_byteenable_s;
    logic [DATA_W-1:0]      sel_writedata_s;
    logic [ADDR_W-1:0]      address_hold_r;
    logic [BE_W-1:0]        byteenable_hold_r;
    logic [DATA_W-1:0]      writedata_hold_r;
    logic [RD_LATENCY-1:0]  tag_valid_r;
    logic [RD_LATENCY-1:0]  tag_id_r;
    logic [CNT_W-1:0]       gnt_cnt0_r;
    logic [CNT_W-1:0]       gnt_cnt1_r;

    // Grant decision: sole requester wins, prio breaks ties, nothing while in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0.req && m1.req) begin
            gnt0_s = ~prio_r;
            gnt1_s = prio_r;
        end else begin
            gnt0_s = m0.req;
            gnt1_s = m1.req;
        end
    end

    assign accept_s = gnt0_s | gnt1_s;

    // Request field mux toward the winner.
    always_comb begin
        if (gnt1_s) begin
            sel_write_s      = m1.write;
            sel_address_s    = m1.address;
            sel_byteenable_s = m1.byteenable;
            sel_writedata_s  = m1.writedata;
        end else begin
            sel_write_s      = m0.write;
            sel_address_s    = m0.address;
            sel_byteenable_s = m0.byteenable;
            sel_writedata_s  = m0.writedata;
        end
    end

    // RAM port drive; idle cycles replay the last accepted fields so the RAM sees no glitches.
    always_comb begin
        ram_chipselect = accept_s;
        ram_write      = accept_s & sel_write_s;
        if (accept_s) begin
            ram_address    = sel_address_s;
            ram_byteenable = sel_byteenable_s;
            ram_writedata  = sel_writedata_s;
        end else begin
            ram_address    = address_hold_r;
            ram_byteenable = byteenable_hold_r;
            ram_writedata  = writedata_hold_r;
        end
    end

    assign ram_clken = 1'b1;

    // Requester responses; readdatavalid is masked during reset so a tag due that cycle is dropped.
    always_comb begin
        m0.waitrequest   = ~gnt0_s;
        m1.waitrequest   = ~gnt1_s;
        m0.readdatavalid = tag_valid_r[RD_LATENCY-1] & ~tag_id_r[RD_LATENCY-1] & ~reset;
        m1.readdatavalid = tag_valid_r[RD_LATENCY-1] &  tag_id_r[RD_LATENCY-1] & ~reset;
        m0.readdata      = ram_readdata;
        m1.readdata      = ram_readdata;
    end

    // Priority pointer and held RAM fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r            <= 1'b0;
            address_hold_r    <= {ADDR_W{1'b0}};
            byteenable_hold_r <= {BE_W{1'b0}};
            writedata_hold_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            prio_r            <= gnt0_s;
            address_hold_r    <= sel_address_s;
            byteenable_hold_r <= sel_byteenable_s;
            writedata_hold_r  <= sel_writedata_s;
        end else begin
            prio_r            <= prio_r;
            address_hold_r    <= address_hold_r;
            byteenable_hold_r <= byteenable_hold_r;
            writedata_hold_r  <= writedata_hold_r;
        end
    end

    // Read tag pipe, aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid_r <= {RD_LATENCY{1'b0}};
            tag_id_r    <= {RD_LATENCY{1'b0}};
        end else begin
            tag_valid_r[0] <= accept_s & ~sel_write_s;
            tag_id_r[0]    <= gnt1_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_id_r[i]    <= tag_id_r[i-1];
            end
        end
    end

    // Debug grant counters, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_cnt0_r <= {CNT_W{1'b0}};
            gnt_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            gnt_cnt0_r <= gnt0_s ? gnt_cnt0_r + CNT_ONE : gnt_cnt0_r;
            gnt_cnt1_r <= gnt1_s ? gnt_cnt1_r + CNT_ONE : gnt_cnt1_r;
        end
    end

    assign gnt_cnt0 = gnt_cnt0_r;
    assign gnt_cnt1 = gnt_cnt1_r;
endmodule

// File: tb/tb_fir_memory_arbiter.sv
// Self-checking bench: two arbiter builds (RD_LATENCY=1/CNT_W=16 and RD_LATENCY=3/CNT_W=4)
// driven with identical traffic and compared against a cycle-indexed behavioural model.
module tb_fir_memory_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 64;
    localparam int BW   = 8;
    localparam int MAXC = 4096;

    typedef struct {
        bit              vreq;
        bit              we;
        logic [AW-1:0]   addr;
        logic [BW-1:0]   be;
        logic [DW-1:0]   wd;
    } req_t;

    req_t q0[$];
    req_t q1[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            d_req[2];
    logic            d_we[2];
    logic [AW-1:0]   d_addr[2];
    logic [BW-1:0]   d_be[2];
    logic [DW-1:0]   d_wd[2];

    fir_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa0 ();
    fir_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa1 ();
    fir_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb0 ();
    fir_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb1 ();

    assign ifa0.req = d_req[0];  assign ifa0.write = d_we[0];  assign ifa0.address = d_addr[0];
    assign ifa0.byteenable = d_be[0];  assign ifa0.writedata = d_wd[0];
    assign ifb0.req = d_req[0];  assign ifb0.write = d_we[0];  assign ifb0.address = d_addr[0];
    assign ifb0.byteenable = d_be[0];  assign ifb0.writedata = d_wd[0];
    assign ifa1.req = d_req[1];  assign ifa1.write = d_we[1];  assign ifa1.address = d_addr[1];
    assign ifa1.byteenable = d_be[1];  assign ifa1.writedata = d_wd[1];
    assign ifb1.req = d_req[1];  assign ifb1.write = d_we[1];  assign ifb1.address = d_addr[1];
    assign ifb1.byteenable = d_be[1];  assign ifb1.writedata = d_wd[1];

    logic            wr0_o[2], wr1_o[2], rdv0_o[2], rdv1_o[2];
    logic [DW-1:0]   rd0_o[2], rd1_o[2];
    assign wr0_o[0] = ifa0.waitrequest;  assign wr1_o[0] = ifa1.waitrequest;
    assign wr0_o[1] = ifb0.waitrequest;  assign wr1_o[1] = ifb1.waitrequest;
    assign rdv0_o[0] = ifa0.readdatavalid;  assign rdv1_o[0] = ifa1.readdatavalid;
    assign rdv0_o[1] = ifb0.readdatavalid;  assign rdv1_o[1] = ifb1.readdatavalid;
    assign rd0_o[0] = ifa0.readdata;  assign rd1_o[0] = ifa1.readdata;
    assign rd0_o[1] = ifb0.readdata;  assign rd1_o[1] = ifb1.readdata;

    logic [AW-1:0]   r_addr[2];
    logic [BW-1:0]   r_be[2];
    logic            r_cs[2], r_we[2], r_clken[2];
    logic [DW-1:0]   r_wd[2], r_rd[2];
    logic [15:0]     cnt0_o[2], cnt1_o[2];
    logic [3:0]      cntb0, cntb1;
    assign cnt0_o[1] = {12'd0, cntb0};
    assign cnt1_o[1] = {12'd0, cntb1};

    fir_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst), .m0(ifa0), .m1(ifa1),
        .ram_address(r_addr[0]), .ram_byteenable(r_be[0]), .ram_chipselect(r_cs[0]),
        .ram_write(r_we[0]), .ram_writedata(r_wd[0]), .ram_clken(r_clken[0]),
        .ram_readdata(r_rd[0]), .gnt_cnt0(cnt0_o[0]), .gnt_cnt1(cnt1_o[0])
    );

    fir_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst), .m0(ifb0), .m1(ifb1),
        .ram_address(r_addr[1]), .ram_byteenable(r_be[1]), .ram_chipselect(r_cs[1]),
        .ram_write(r_we[1]), .ram_writedata(r_wd[1]), .ram_clken(r_clken[1]),
        .ram_readdata(r_rd[1]), .gnt_cnt0(cntb0), .gnt_cnt1(cntb1)
    );

    // RAM behavioural models: one per build, read latency 1 and 3.
    logic [DW-1:0] mem [2][16384];
    logic [DW-1:0] rpipe [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (r_cs[k] && r_we[k])
                for (int b = 0; b < BW; b++)
                    if (r_be[k][b]) mem[k][r_addr[k]][b*8 +: 8] <= r_wd[k][b*8 +: 8];
            rpipe[k][0] <= mem[k][r_addr[k]];
            rpipe[k][1] <= rpipe[k][0];
            rpipe[k][2] <= rpipe[k][1];
        end
    end
    assign r_rd[0] = rpipe[0][0];
    assign r_rd[1] = rpipe[1][2];

    // Reference model state
    bit              prio_m;
    int              cnt_m[2];
    logic [AW-1:0]   last_addr_m;
    logic [DW-1:0]   ref_mem [16384];
    int              cyc;
    bit              iss_v [MAXC];
    bit              iss_id [MAXC];
    logic [DW-1:0]   iss_d [MAXC];
    int              lat[2]   = '{1, 3};
    int              cmask[2] = '{65535, 15};
    logic [DW-1:0]   seen_rd0;
    int              nv0[2], nv1[2];
    int              n_checks, n_errors;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic req_t mk(bit vreq, bit we, int a, int be, logic [DW-1:0] wd);
        req_t e;
        e.vreq = vreq;  e.we = we;  e.addr = AW'(a);  e.be = BW'(be);  e.wd = wd;
        return e;
    endfunction

    task automatic push(input int who, input req_t e);
        if (who == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic cycle();
        req_t e0, e1, s;
        bit p0, p1, g0, g1, acc, ev0, ev1;
        int src;
        logic [DW-1:0] ed;
        e0 = (q0.size() > 0) ? q0[0] : mk(1'b0, 1'b0, 0, 0, 64'd0);
        e1 = (q1.size() > 0) ? q1[0] : mk(1'b0, 1'b0, 0, 0, 64'd0);
        p0 = e0.vreq;
        p1 = e1.vreq;
        d_req[0] = p0;  d_we[0] = e0.we;  d_addr[0] = e0.addr;  d_be[0] = e0.be;  d_wd[0] = e0.wd;
        d_req[1] = p1;  d_we[1] = e1.we;  d_addr[1] = e1.addr;  d_be[1] = e1.be;  d_wd[1] = e1.wd;
        @(negedge clk);
        if (rst) begin
            g0 = 1'b0; g1 = 1'b0;
        end else if (p0 && p1) begin
            g0 = !prio_m; g1 = prio_m;
        end else begin
            g0 = p0; g1 = p1;
        end
        acc = g0 | g1;
        s = g1 ? e1 : e0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("d%0d_wait0", k), 64'(wr0_o[k]), 64'(!g0));
            check_eq($sformatf("d%0d_wait1", k), 64'(wr1_o[k]), 64'(!g1));
            check_eq($sformatf("d%0d_cs", k), 64'(r_cs[k]), 64'(acc));
            check_eq($sformatf("d%0d_ramwr", k), 64'(r_we[k]), 64'(acc & s.we));
            check_eq($sformatf("d%0d_addr", k), 64'(r_addr[k]), 64'(acc ? s.addr : last_addr_m));
            check_eq($sformatf("d%0d_clken", k), 64'(r_clken[k]), 64'd1);
            if (acc && s.we) begin
                check_eq($sformatf("d%0d_be", k), 64'(r_be[k]), 64'(s.be));
                check_eq($sformatf("d%0d_wd", k), r_wd[k], s.wd);
            end
            ev0 = 1'b0; ev1 = 1'b0; ed = 64'd0;
            src = cyc - lat[k];
            if (!rst && src >= 0 && src < MAXC && iss_v[src]) begin
                ev0 = !iss_id[src]; ev1 = iss_id[src]; ed = iss_d[src];
            end
            check_eq($sformatf("d%0d_rdv0", k), 64'(rdv0_o[k]), 64'(ev0));
            check_eq($sformatf("d%0d_rdv1", k), 64'(rdv1_o[k]), 64'(ev1));
            if (ev0) check_eq($sformatf("d%0d_rdata0", k), rd0_o[k], ed);
            if (ev1) check_eq($sformatf("d%0d_rdata1", k), rd1_o[k], ed);
            check_eq($sformatf("d%0d_cnt0", k), 64'(cnt0_o[k]), 64'(cnt_m[0] & cmask[k]));
            check_eq($sformatf("d%0d_cnt1", k), 64'(cnt1_o[k]), 64'(cnt_m[1] & cmask[k]));
            if (rdv0_o[k]) begin
                nv0[k]++;
                if (k == 0) seen_rd0 = rd0_o[0];
            end
            if (rdv1_o[k]) nv1[k]++;
        end
        @(posedge clk);
        if (rst) begin
            prio_m = 1'b0;
            cnt_m[0] = 0;
            cnt_m[1] = 0;
            last_addr_m = '0;
            for (int i = 1; i <= 4; i++) if (cyc - i >= 0) iss_v[cyc-i] = 1'b0;
        end else if (acc) begin
            prio_m = g0;
            cnt_m[int'(g1)]++;
            last_addr_m = s.addr;
            if (s.we) begin
                for (int b = 0; b < BW; b++)
                    if (s.be[b]) ref_mem[s.addr][b*8 +: 8] = s.wd[b*8 +: 8];
            end else if (cyc < MAXC) begin
                iss_v[cyc] = 1'b1;  iss_id[cyc] = g1;  iss_d[cyc] = ref_mem[s.addr];
            end
        end
        if (q0.size() > 0 && (!q0[0].vreq || g0)) void'(q0.pop_front());
        if (q1.size() > 0 && (!q1[0].vreq || g1)) void'(q1.pop_front());
        cyc++;
        #1;
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < max) begin
            cycle();
            n++;
        end
        check_eq("queue_drain", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        repeat (4) cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int b0, b1;
        n_checks = 0; n_errors = 0; cyc = 0; prio_m = 1'b0;
        cnt_m[0] = 0; cnt_m[1] = 0; last_addr_m = '0;
        nv0[0] = 0; nv0[1] = 0; nv1[0] = 0; nv1[1] = 0; seen_rd0 = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = {$urandom, $urandom};
        ref_mem[5]      = 64'h0123_4567_89AB_CDEF;
        ref_mem[16383]  = 64'd0;
        for (int i = 0; i < 16384; i++) begin
            mem[0][i] <= ref_mem[i];
            mem[1][i] <= ref_mem[i];
        end
        for (int k = 0; k < 2; k++) begin
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_be[k] = '0; d_wd[k] = '0;
        end
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;

        // Single m0 read from 0x0005
        b1 = nv1[0];
        push(0, mk(1'b1, 1'b0, 5, 0, 64'd0));
        run(20);
        check_eq("s1_rdata", seen_rd0, 64'h0123_4567_89AB_CDEF);
        check_eq("s1_m1_quiet", 64'(nv1[0]), 64'(b1));
        check_eq("s1_cnt0", 64'(cnt0_o[0]), 64'd1);

        // Request held across a reset cycle is only accepted afterwards
        push(1, mk(1'b1, 1'b0, 9, 0, 64'd0));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(20);

        // m0 read immediately followed by reset: the read must vanish
        b0 = nv0[0]; b1 = nv0[1];
        push(0, mk(1'b1, 1'b0, 7, 0, 64'd0));
        cycle();
        pulse_reset();
        repeat (4) cycle();
        check_eq("rst_drop_a", 64'(nv0[0]), 64'(b0));
        check_eq("rst_drop_b", 64'(nv0[1]), 64'(b1));
        check_eq("rst_cnt0", 64'(cnt0_o[0]), 64'd0);
        check_eq("rst_cs", 64'(r_cs[0]), 64'd0);

        // Continuous contention: strict alternation starting with m0
        b0 = nv0[0]; b1 = nv1[0];
        for (int i = 0; i < 4; i++) begin
            push(0, mk(1'b1, 1'b0, 16 + i, 0, 64'd0));
            push(1, mk(1'b1, 1'b0, 16'h2000 + i, 0, 64'd0));
        end
        run(20);
        check_eq("cont_cnt0", 64'(cnt0_o[0]), 64'd4);
        check_eq("cont_cnt1", 64'(cnt1_o[0]), 64'd4);
        check_eq("cont_rdv0", 64'(nv0[0] - b0), 64'd4);
        check_eq("cont_rdv1", 64'(nv1[0] - b1), 64'd4);

        // Partial write by m1 then read-back by m0
        push(1, mk(1'b1, 1'b1, 16383, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF));
        push(0, mk(1'b0, 1'b0, 0, 0, 64'd0));
        push(0, mk(1'b1, 1'b0, 16383, 0, 64'd0));
        run(20);
        check_eq("wr_readback", seen_rd0, 64'h0000_0000_FFFF_FFFF);

        // Counter wrap on the CNT_W=4 build
        pulse_reset();
        for (int i = 0; i < 16; i++) push(1, mk(1'b1, 1'b0, $urandom_range(0, 16383), 0, 64'd0));
        run(40);
        check_eq("wrap_16", 64'(cnt1_o[1]), 64'd0);
        check_eq("wide_16", 64'(cnt1_o[0]), 64'd16);
        push(1, mk(1'b1, 1'b0, 3, 0, 64'd0));
        run(10);
        check_eq("wrap_17", 64'(cnt1_o[1]), 64'd1);

        // Alternating reads on the RD_LATENCY=3 build
        b0 = nv0[1]; b1 = nv1[1];
        for (int i = 0; i < 3; i++) begin
            push(0, mk(1'b1, 1'b0, 1, 0, 64'd0));
            push(1, mk(1'b1, 1'b0, 2, 0, 64'd0));
        end
        run(20);
        check_eq("lat3_rdv0", 64'(nv0[1] - b0), 64'd3);
        check_eq("lat3_rdv1", 64'(nv1[1] - b1), 64'd3);

        // Randomized mixed traffic
        pulse_reset();
        for (int i = 0; i < 80; i++) begin
            for (int w = 0; w < 2; w++) begin
                int a;
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 31));
                push(w, mk($urandom_range(0, 9) > 2, $urandom_range(0, 1) == 1, a,
                           int'($urandom_range(0, 255)), {$urandom, $urandom}));
            end
        end
        run(600);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
